uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
// - UART receive controller directly upstream of the RX majority-vote sampler (module sampler).
// - Detects the start bit, runs the oversampling edge counter and bit counter, drives the sampler enable and edge_cnt.
// - Consumes sampled_bit: checks the start bit, deserializes data LSB-first, checks parity and stop bit.
// - Presents each received byte with a one-cycle valid pulse, plus per-frame error flags.
// PARAMETERS
// - DATA_WIDTH  8  data bits per frame
// - PRESC_W     6  width of prescale and edge_cnt; must match the sampler's 6-bit ports
// PORTS
// - clk           in   1           system clock
// - rst           in   1           asynchronous, active-low reset
// - rx_in         in   1           serial line, already synchronized to clk; idle high
// - prescale      in   PRESC_W     oversampling ratio; legal values 8, 16, 32; static during a frame
// - par_en        in   1           1 = frame carries a parity bit
// - par_typ       in   1           0 = even, 1 = odd; static during a frame
// - sampled_bit   in   1           majority-vote result from the sampler
// - sampler_en    out  1           enable to the sampler
// - edge_cnt      out  PRESC_W     oversampling edge index within the current bit, to the sampler
// - p_data        out  DATA_WIDTH  received byte, held until the next valid frame
// - data_valid    out  1           one-cycle pulse: p_data is a new, error-free byte
// - par_err       out  1           parity mismatch in the current/last frame
// - stp_err       out  1           stop bit sampled low in the current/last frame
// BEHAVIOUR
// - Reset values (async, immediate, also mid-frame): state IDLE, edge_cnt 0, bit_cnt 0, sampler_en 0.
// - Reset values, continued: p_data 0, data_valid 0, par_err 0, stp_err 0.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - sampler_en is 1 in every state except IDLE.
// - Edge/bit counter: in non-IDLE states, edge_cnt counts 0..prescale-1.
//   - At prescale-1 it wraps to 0 and bit_cnt increments.
//   - In IDLE, edge_cnt and bit_cnt are held at 0.
// - Bit-end decision point ("BE"): the cycle with edge_cnt == prescale-1.
//   - The sampler registers sampled_bit at mid+1, so sampled_bit is stable by BE.
//   - All checks use sampled_bit at BE.
// - IDLE -> START: rx_in == 0 on any cycle.
//   - On this transition, edge_cnt = 0 and bit_cnt = 0 on the next cycle; par_err and stp_err clear.
// - START, at BE:
//   - sampled_bit == 1 -> glitch; return to IDLE with no outputs and no flags.
//   - Otherwise go to DATA.
// - DATA, at each BE: p_data shift register <= {sampled_bit, shreg[DATA_WIDTH-1:1]} (LSB first).
//   - After DATA_WIDTH bits, go to PARITY if par_en, else STOP.
//   - Bytes are assembled in an internal shift register; p_data updates only on data_valid.
// - PARITY, at BE:
//   - Expected bit = ^shreg (even) or ~^shreg (odd).
//   - Mismatch -> par_err <= 1. Then go to STOP.
// - STOP, at BE:
//   - sampled_bit == 0 -> stp_err <= 1.
//   - If no error in this frame: data_valid = 1 for exactly the next cycle and p_data <= shreg.
//   - Go to IDLE.
// - Latency: data_valid rises 1 clk after the stop-bit BE.
// - Error flags are sticky until the next START entry.
// - Back-to-back frames: IDLE is entered for at least 1 clk, then a low rx_in starts the next frame.
//   - One-clock slip per frame is tolerated; no frame is lost.
// - Line held low after a stop error is treated as a new start bit in IDLE.
// - prescale or par_en changed mid-frame: behaviour undefined; no assertion of lock-up required.
//   - The FSM must still return to IDLE within DATA_WIDTH+3 bit times.
// - Arithmetic: edge_cnt compare done at PRESC_W bits; bit_cnt width $clog2(DATA_WIDTH+1); no overflow possible.
// STRUCTURE
// - Shared package uart_rx_pkg: FSM state encoding localparams; PAR_EVEN = 1'b0 and PAR_ODD = 1'b1.
//   - The package is shared with the TX side.
// - Sub-module uart_rx_edge_bit_cnt.
//   - Inputs: clk, rst, enable, prescale. Outputs: edge_cnt, bit_cnt, bit_end.
//   - The FSM, deserializer, and parity/stop checks stay in uart_rx_ctrl.
// TESTING
// - Bench instantiates uart_rx_ctrl with the sampler; a bit-accurate serial driver; scoreboard on data_valid.
// - prescale 8, par_en 1 even, frame 0xA5 with parity bit 0 -> data_valid pulse, p_data 0xA5, par_err 0, stp_err 0.
// - prescale 8, rx_in low for 2 clks then high -> START aborts at BE, back in IDLE, no data_valid, flags 0.
// - prescale 16, par_en 1 even, 0xA5 with parity bit 1 -> par_err 1, no data_valid, p_data keeps previous value.
// - prescale 32, par_en 0, 0x3C with stop bit 0 -> stp_err 1, no data_valid; next good frame 0x55 -> valid, flags cleared.
// - prescale 16, par_en 1 odd, back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses, 0x00 then 0xFF.
// - rst asserted low mid-DATA (bit 4) -> all outputs at reset values the same cycle; next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared UART definitions: FSM state encoding and parity types.
//            Used by both the receive and transmit controllers.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Frame-level FSM encoding
  localparam int unsigned c_STATE_W = 3;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_IDLE   = 3'd0;
  localparam state_t c_ST_START  = 3'd1;
  localparam state_t c_ST_DATA   = 3'd2;
  localparam state_t c_ST_PARITY = 3'd3;
  localparam state_t c_ST_STOP   = 3'd4;

  // Parity type selector values
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl_if
// Purpose  : Bundles the sampler link (enable, edge index, voted bit) and the
//            received-byte result bus of the UART receive controller.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);

  logic                  sampler_en;
  logic [PRESC_W-1:0]    edge_cnt;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  // Controller side
  modport master (
    output sampler_en, edge_cnt, p_data, data_valid, par_err, stp_err,
    input  sampled_bit
  );

  // Sampler / consumer side
  modport slave (
    input  sampler_en, edge_cnt, p_data, data_valid, par_err, stp_err,
    output sampled_bit
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_edge_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_edge_bit_cnt
// Purpose  : Oversampling edge counter (0..prescale-1) and bit counter for
//            the UART receiver. bit_end flags the last edge of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W   = 6,
  parameter int BIT_CNT_W = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 enable,
  input  wire logic [PRESC_W-1:0]   prescale,
  output logic      [PRESC_W-1:0]   edge_cnt,
  output logic      [BIT_CNT_W-1:0] bit_cnt,
  output logic                      bit_end
);

  localparam logic [PRESC_W-1:0] c_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0]   r_edge_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [PRESC_W-1:0]   w_last;

  // '>=' rather than '==' so a prescale shrunk mid-frame still wraps the count
  assign w_last  = prescale - c_ONE;
  assign bit_end = enable && (r_edge_cnt >= w_last);

  // Edge counter wraps at the bit end and advances the bit counter; both held at 0 while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!enable) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (bit_end) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 1'b1;
    end else begin
      r_edge_cnt <= r_edge_cnt + c_ONE;
    end
  end

  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive controller. Detects the start bit, drives the
//            majority-vote sampler, deserializes LSB-first, checks parity
//            and stop bit, and pulses data_valid for each error-free byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               rx_in,
  input  wire logic [PRESC_W-1:0] prescale,
  input  wire logic               par_en,
  input  wire logic               par_typ,
  uart_rx_ctrl_if.master          bus
);

  localparam int                     c_BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  // Bit counter reads 1 during the first data bit (the start bit is bit 0)
  localparam logic [c_BIT_CNT_W-1:0] c_LAST_DATA = c_BIT_CNT_W'(DATA_WIDTH);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_sampler_en;
  logic                    w_start_entry;
  logic                    w_shift;
  logic                    w_par_chk;
  logic                    w_stp_chk;
  logic                    w_par_exp;
  logic                    w_bit_end;
  logic [PRESC_W-1:0]      w_edge_cnt;
  logic [c_BIT_CNT_W-1:0]  w_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic [DATA_WIDTH-1:0]   r_p_data;
  logic                    r_data_valid;
  logic                    r_par_err;
  logic                    r_stp_err;

  uart_rx_edge_bit_cnt #(
    .PRESC_W   (PRESC_W),
    .BIT_CNT_W (c_BIT_CNT_W)
  ) u_edge_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .enable   (w_sampler_en),
    .prescale (prescale),
    .edge_cnt (w_edge_cnt),
    .bit_cnt  (w_bit_cnt),
    .bit_end  (w_bit_end)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_ST_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic; every non-IDLE state leaves at a bit end, so a frame always terminates
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (!rx_in)    w_next = c_ST_START;
      c_ST_START:  if (w_bit_end) w_next = bus.sampled_bit ? c_ST_IDLE : c_ST_DATA;
      c_ST_DATA:   if (w_bit_end && (w_bit_cnt >= c_LAST_DATA))
                                  w_next = par_en ? c_ST_PARITY : c_ST_STOP;
      c_ST_PARITY: if (w_bit_end) w_next = c_ST_STOP;
      c_ST_STOP:   if (w_bit_end) w_next = c_ST_IDLE;
      default:                    w_next = c_ST_IDLE;
    endcase
  end

  // FSM outputs: sampler enable and per-state bit-end strobes
  always_comb begin
    w_sampler_en  = (r_state != c_ST_IDLE);
    w_start_entry = (r_state == c_ST_IDLE)   && !rx_in;
    w_shift       = (r_state == c_ST_DATA)   && w_bit_end;
    w_par_chk     = (r_state == c_ST_PARITY) && w_bit_end;
    w_stp_chk     = (r_state == c_ST_STOP)   && w_bit_end;
  end

  // Expected parity bit for the assembled byte
  always_comb begin
    w_par_exp = ^r_shreg;
    case (par_typ)
      PAR_EVEN: w_par_exp = ^r_shreg;
      PAR_ODD:  w_par_exp = ~^r_shreg;
      default:  w_par_exp = ^r_shreg;
    endcase
  end

  // LSB-first deserializer: each new bit enters at the MSB and shifts down
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_shreg <= '0;
    else if (w_shift) r_shreg <= {bus.sampled_bit, r_shreg[DATA_WIDTH-1:1]};
  end

  // Sticky per-frame error flags, cleared on entry to START
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
    end else if (w_start_entry) begin
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
    end else begin
      if (w_par_chk && (bus.sampled_bit != w_par_exp)) r_par_err <= 1'b1;
      if (w_stp_chk && !bus.sampled_bit)               r_stp_err <= 1'b1;
    end
  end

  // Byte hand-off: one-cycle valid after a clean stop bit; p_data holds between good frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_valid <= 1'b0;
      r_p_data     <= '0;
    end else begin
      r_data_valid <= w_stp_chk && bus.sampled_bit && !r_par_err;
      if (w_stp_chk && bus.sampled_bit && !r_par_err) r_p_data <= r_shreg;
    end
  end

  assign bus.sampler_en = w_sampler_en;
  assign bus.edge_cnt   = w_edge_cnt;
  assign bus.p_data     = r_p_data;
  assign bus.data_valid = r_data_valid;
  assign bus.par_err    = r_par_err;
  assign bus.stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl with a behavioural
//            majority-vote sampler, serial line driver and valid scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;

  uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .prescale (prescale),
    .par_en   (par_en),
    .par_typ  (par_typ),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sampler model: votes on the three edges around mid-bit, registers at mid+1
  logic       s0;
  logic       s1;
  logic [5:0] mid;
  assign mid = prescale >> 1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      bus.sampled_bit <= 1'b0;
    end else if (bus.sampler_en) begin
      if (bus.edge_cnt == mid - 6'd1) s0 <= rx_in;
      if (bus.edge_cnt == mid)        s1 <= rx_in;
      if (bus.edge_cnt == mid + 6'd1)
        bus.sampled_bit <= (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
    end
  end

  // Scoreboard: every cycle with data_valid high is one received byte
  int         n_pulse = 0;
  logic [7:0] rxq[$];
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      n_pulse = n_pulse + 1;
      rxq.push_back(bus.p_data);
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (int'(prescale)) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  typedef struct {
    logic [5:0] presc;
    logic       pen;
    logic       ptyp;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         exp_pulses;
    logic [7:0] exp_pdata;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    // presc pen ptyp data pbit stop | pulses pdata perr serr
    vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{6'd16, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{6'd32, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{6'd32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{6'd16, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{6'd8,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b0};

    rst      = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_sampler_en", 32'(bus.sampler_en), 32'd0);
    check("rst_edge_cnt",   32'(bus.edge_cnt),   32'd0);
    check("rst_p_data",     32'(bus.p_data),     32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_par_err",    32'(bus.par_err),    32'd0);
    check("rst_stp_err",    32'(bus.stp_err),    32'd0);
    rst = 1'b1;
    repeat (4) tick();

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      prescale = vecs[v].presc;
      par_en   = vecs[v].pen;
      par_typ  = vecs[v].ptyp;
      repeat (4) tick();
      base = n_pulse;
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop);
      repeat (2 * int'(vecs[v].presc)) tick();
      check($sformatf("v%0d_pulses", v),  32'(n_pulse - base),   32'(vecs[v].exp_pulses));
      check($sformatf("v%0d_p_data", v),  32'(bus.p_data),       32'(vecs[v].exp_pdata));
      check($sformatf("v%0d_par_err", v), 32'(bus.par_err),      32'(vecs[v].exp_perr));
      check($sformatf("v%0d_stp_err", v), 32'(bus.stp_err),      32'(vecs[v].exp_serr));
      check($sformatf("v%0d_idle", v),    32'(bus.sampler_en),   32'd0);
    end

    // Glitch: two low clocks, start bit votes high at its bit end
    prescale = 6'd8;
    par_en   = 1'b1;
    par_typ  = 1'b0;
    repeat (4) tick();
    base  = n_pulse;
    rx_in = 1'b0;
    tick();
    tick();
    rx_in = 1'b1;
    check("glitch_started", 32'(bus.sampler_en), 32'd1);
    repeat (12) tick();
    check("glitch_idle",     32'(bus.sampler_en), 32'd0);
    check("glitch_edge_cnt", 32'(bus.edge_cnt),   32'd0);
    check("glitch_pulses",   32'(n_pulse - base), 32'd0);
    check("glitch_par_err",  32'(bus.par_err),    32'd0);
    check("glitch_stp_err",  32'(bus.stp_err),    32'd0);

    // Back-to-back odd-parity frames with no idle gap
    prescale = 6'd16;
    par_en   = 1'b1;
    par_typ  = 1'b1;
    repeat (4) tick();
    base = n_pulse;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
    repeat (32) tick();
    check("b2b_pulses", 32'(n_pulse - base), 32'd2);
    if (n_pulse - base >= 2) begin
      check("b2b_first",  32'(rxq[base]),     32'h00);
      check("b2b_second", 32'(rxq[base + 1]), 32'hFF);
    end
    check("b2b_par_err", 32'(bus.par_err), 32'd0);
    check("b2b_stp_err", 32'(bus.stp_err), 32'd0);

    // Asynchronous reset in the middle of data bit 4 of 0x81
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (4) tick();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx_in = 1'b0;
    repeat (3) tick();
    check("mid_active", 32'(bus.sampler_en), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_sampler_en", 32'(bus.sampler_en), 32'd0);
    check("mid_edge_cnt",   32'(bus.edge_cnt),   32'd0);
    check("mid_p_data",     32'(bus.p_data),     32'd0);
    check("mid_data_valid", 32'(bus.data_valid), 32'd0);
    check("mid_par_err",    32'(bus.par_err),    32'd0);
    check("mid_stp_err",    32'(bus.stp_err),    32'd0);
    rx_in = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (16) tick();
    base = n_pulse;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (16) tick();
    check("post_rst_pulses", 32'(n_pulse - base), 32'd1);
    check("post_rst_p_data", 32'(bus.p_data),     32'h81);
    check("post_rst_flags",  32'({bus.par_err, bus.stp_err}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
